// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter.
//
// Sends one word per frame: a start bit, 5..DBIT_MAX data bits (LSB first), optional
// even/odd parity, and 1, 1.5 or 2 stop bits. Bit timing comes from an external
// oversample tick, with OVERSAMPLE ticks per bit.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   s_tick       one-cycle oversample tick from the baud generator
//   tx_start     send request, taken only while tx_ready=1
//   din          data word, bit 0 sent first
//   cfg_dbit     data bits per frame, clamped to 5..DBIT_MAX when the frame is accepted
//   cfg_par      00 none, 01 even, 10 odd, 11 none
//   cfg_stop     00 one stop bit, 01 one and a half, 10/11 two
//   tx_break     holds the line low while idle
//   tx           registered serial output, idles high
//   tx_ready     idle and not in break
//   tx_busy      frame in flight, from the acceptance edge to the end of the stop period
//   tx_done_tick one-cycle pulse on the final stop tick
module uart_tx_cfg #(
    parameter int unsigned DBIT_MAX   = 8,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             s_tick,
    input  logic                             tx_start,
    input  logic [DBIT_MAX-1:0]              din,
    input  logic [$clog2(DBIT_MAX+1)-1:0]    cfg_dbit,
    input  logic [1:0]                       cfg_par,
    input  logic [1:0]                       cfg_stop,
    input  logic                             tx_break,
    output logic                             tx,
    output logic                             tx_ready,
    output logic                             tx_busy,
    output logic                             tx_done_tick
);

    localparam int unsigned DW = $clog2(DBIT_MAX + 1);
    localparam int unsigned TW = $clog2(2 * OVERSAMPLE);

    localparam logic [TW-1:0] BitLast    = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] Stop15Last = TW'((3 * OVERSAMPLE) / 2 - 1);
    localparam logic [TW-1:0] Stop2Last  = TW'(2 * OVERSAMPLE - 1);
    localparam logic [DW-1:0] DbitMin    = DW'(5);
    localparam logic [DW-1:0] DbitMax    = DW'(DBIT_MAX);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } state_e;

    state_e                state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [DW-1:0]         bit_q, bit_d;
    logic [DW-1:0]         dbit_q, dbit_d;
    logic [DBIT_MAX-1:0]   shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [TW-1:0]         stop_last_q, stop_last_d;
    logic                  tx_q, tx_d;
    logic                  done;

    // Acceptance-time view of the request: clamped width, masked word and its parity.
    logic [DW-1:0]         dbit_clamp;
    logic [DBIT_MAX-1:0]   din_mask;
    logic [DBIT_MAX-1:0]   din_masked;
    logic                  par_calc;
    logic [TW-1:0]         stop_calc;
    logic                  bit_end;

    always_comb begin
        if (cfg_dbit < DbitMin) begin
            dbit_clamp = DbitMin;
        end else if (cfg_dbit > DbitMax) begin
            dbit_clamp = DbitMax;
        end else begin
            dbit_clamp = cfg_dbit;
        end
        din_mask = '0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            din_mask[i] = (DW'(i) < dbit_clamp);
        end
        din_masked = din & din_mask;
        // Even parity is the XOR of the sent bits; odd is its complement.
        par_calc   = (^din_masked) ^ (cfg_par == 2'b10);
        case (cfg_stop)
            2'b00:   stop_calc = BitLast;
            2'b01:   stop_calc = Stop15Last;
            default: stop_calc = Stop2Last;
        endcase
    end

    assign bit_end = s_tick && (tick_q == BitLast);

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        dbit_d      = dbit_q;
        shift_d     = shift_q;
        par_en_d    = par_en_q;
        par_bit_d   = par_bit_q;
        stop_last_d = stop_last_q;
        tx_d        = 1'b1;
        done        = 1'b0;

        if (s_tick) begin
            tick_d = tick_q + TW'(1);
        end

        case (state_q)
            StIdle: begin
                tx_d   = ~tx_break;
                // Ticks while idle, including the acceptance cycle, are never counted.
                tick_d = '0;
                if (tx_start && !tx_break) begin
                    state_d     = StStart;
                    bit_d       = '0;
                    dbit_d      = dbit_clamp;
                    shift_d     = din_masked;
                    par_en_d    = cfg_par[0] ^ cfg_par[1];
                    par_bit_d   = par_calc;
                    stop_last_d = stop_calc;
                end
            end
            StStart: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    state_d = StData;
                    tick_d  = '0;
                end
            end
            StData: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == dbit_q - DW'(1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? StPar : StStop;
                    end else begin
                        bit_d = bit_q + DW'(1);
                    end
                end
            end
            StPar: begin
                tx_d = par_bit_q;
                if (bit_end) begin
                    state_d = StStop;
                    tick_d  = '0;
                end
            end
            StStop: begin
                tx_d = 1'b1;
                if (s_tick && (tick_q == stop_last_q)) begin
                    done    = 1'b1;
                    state_d = StIdle;
                    tick_d  = '0;
                end
            end
            default: begin
                state_d = StIdle;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            tick_q      <= '0;
            bit_q       <= '0;
            dbit_q      <= DbitMin;
            shift_q     <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop_last_q <= BitLast;
            tx_q        <= 1'b1;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            dbit_q      <= dbit_d;
            shift_q     <= shift_d;
            par_en_q    <= par_en_d;
            par_bit_q   <= par_bit_d;
            stop_last_q <= stop_last_d;
            tx_q        <= tx_d;
        end
    end

    assign tx           = tx_q;
    assign tx_busy      = (state_q != StIdle);
    assign tx_ready     = (state_q == StIdle) && !tx_break;
    // A reset landing on the last stop tick still aborts the frame silently.
    assign tx_done_tick = done && !reset;

endmodule

// File: tb/tb_uart_tx_cfg.sv
module tb_uart_tx_cfg;

    localparam int Os = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       s_tick;
    logic       tx_start;
    logic [7:0] din;
    logic [3:0] cfg_dbit;
    logic [1:0] cfg_par;
    logic [1:0] cfg_stop;
    logic       tx_break;
    logic       tx;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done_tick;

    always #5 clk = ~clk;

    uart_tx_cfg #(
        .DBIT_MAX   (8),
        .OVERSAMPLE (Os)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (tx_start),
        .din          (din),
        .cfg_dbit     (cfg_dbit),
        .cfg_par      (cfg_par),
        .cfg_stop     (cfg_stop),
        .tx_break     (tx_break),
        .tx           (tx),
        .tx_ready     (tx_ready),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    bit got_q[$];
    logic s_done, s_busy, s_ready, s_tx;

    typedef struct {
        logic [7:0] din;
        int dbit;
        int par;
        int stop;
        int exp_len;
        int exp_nd;
        int exp_par;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // One clock: combinational outputs sampled mid-cycle, tx sampled just after the edge.
    task automatic step(input logic tk);
        s_tick = tk;
        #1;
        s_done  = tx_done_tick;
        s_busy  = tx_busy;
        s_ready = tx_ready;
        @(posedge clk);
        #1;
        s_tx = tx;
    endtask

    // Expected line level for every oversample tick of a frame.
    task automatic build(input logic [7:0] d, input int db, input int pr, input int sp,
                         output int nd);
        int masked, p, st;
        nd = (db < 5) ? 5 : ((db > 8) ? 8 : db);
        masked = int'(d) & ((1 << nd) - 1);
        p = $countones(masked) % 2;
        if (pr == 2) p = 1 - p;
        st = (sp == 0) ? Os : ((sp == 1) ? (Os * 3) / 2 : 2 * Os);
        exp_q.delete();
        repeat (Os) exp_q.push_back(1'b0);
        for (int i = 0; i < nd; i++) begin
            repeat (Os) exp_q.push_back(bit'((masked >> i) & 1));
        end
        if (pr == 1 || pr == 2) begin
            repeat (Os) exp_q.push_back(bit'(p));
        end
        repeat (st) exp_q.push_back(1'b1);
    endtask

    task automatic send(input logic [7:0] d, input int db, input int pr, input int sp,
                        input int per, input bit tick_acc, input bit disturb, input bit chain,
                        input string name);
        int nd, cyc, busy_bad, bad;
        bit done_seen, first, dist_done, tk;
        build(d, db, pr, sp, nd);
        din      = d;
        cfg_dbit = 4'(db);
        cfg_par  = 2'(pr);
        cfg_stop = 2'(sp);
        tx_start = 1'b1;
        step(tick_acc);
        check(s_ready == 1'b1, {name, " ready"}, int'(s_ready), 1);
        check(s_busy == 1'b0, {name, " idle busy"}, int'(s_busy), 0);
        tx_start  = 1'b0;
        got_q.delete();
        cyc       = 0;
        busy_bad  = 0;
        done_seen = 1'b0;
        first     = 1'b1;
        dist_done = 1'b0;
        while (!done_seen && cyc < 4000) begin
            tk = ((cyc % per) == per - 1);
            if (disturb && !dist_done && got_q.size() == 3 * Os) begin
                tx_start = 1'b1;
                din      = 8'hAA;
                cfg_dbit = 4'd5;
                cfg_par  = 2'd2;
                cfg_stop = 2'd3;
                tx_break = 1'b1;
                step(tk);
                tx_start  = 1'b0;
                dist_done = 1'b1;
            end else begin
                step(tk);
            end
            if (first) begin
                check(s_tx == 1'b0, {name, " start edge"}, int'(s_tx), 0);
                first = 1'b0;
            end
            if (!s_busy) busy_bad++;
            if (tk) got_q.push_back(s_tx);
            if (s_done) begin
                done_seen = 1'b1;
                check(tk, {name, " done on tick"}, int'(tk), 1);
            end
            cyc++;
        end
        check(done_seen, {name, " done seen"}, int'(done_seen), 1);
        check(got_q.size() == exp_q.size(), {name, " ticks"}, got_q.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            if (bad < 0 && got_q[i] != exp_q[i]) bad = i;
        end
        check(bad < 0, {name, " line first bad tick"}, bad, -1);
        check(busy_bad == 0, {name, " busy drops"}, busy_bad, 0);
        if (!chain) begin
            step(1'b0);
            check(s_busy == 1'b0, {name, " busy after"}, int'(s_busy), 0);
            check(s_done == 1'b0, {name, " single done"}, int'(s_done), 0);
            check(s_ready == !tx_break, {name, " ready after"}, int'(s_ready), int'(!tx_break));
            check(s_tx == !tx_break, {name, " idle line"}, int'(s_tx), int'(!tx_break));
        end
    endtask

    initial begin
        int n, cyc, dones;
        tbl[0] = '{8'h55, 8, 0, 0, 160, 8, -1};
        tbl[1] = '{8'h83, 7, 1, 0, 160, 7, 0};
        tbl[2] = '{8'h1F, 5, 2, 2, 144, 5, 0};
        tbl[3] = '{8'h00, 8, 0, 1, 168, 8, -1};
        tbl[4] = '{8'hFF, 8, 0, 0, 160, 8, -1};
        tbl[5] = '{8'h07, 3, 1, 0, 128, 5, 1};
        tbl[6] = '{8'h01, 15, 1, 0, 176, 8, 1};

        reset    = 1'b1;
        s_tick   = 1'b0;
        tx_start = 1'b0;
        din      = '0;
        cfg_dbit = 4'd8;
        cfg_par  = '0;
        cfg_stop = '0;
        tx_break = 1'b0;
        step(1'b0);
        step(1'b1);
        reset = 1'b0;
        step(1'b0);
        check(s_tx == 1'b1, "reset tx", int'(s_tx), 1);
        check(s_ready == 1'b1, "reset ready", int'(s_ready), 1);
        check(s_busy == 1'b0, "reset busy", int'(s_busy), 0);
        check(s_done == 1'b0, "reset done", int'(s_done), 0);

        // Directed frames; entry 3 chains straight into entry 4 with no idle cycle.
        for (int i = 0; i < 7; i++) begin
            send(tbl[i].din, tbl[i].dbit, tbl[i].par, tbl[i].stop, 4, bit'(i % 2), 1'b0,
                 (i == 3), $sformatf("vec%0d", i));
            check(got_q.size() == tbl[i].exp_len, $sformatf("vec%0d len", i), got_q.size(),
                  tbl[i].exp_len);
            if (tbl[i].exp_par >= 0 && got_q.size() > Os * (1 + tbl[i].exp_nd)) begin
                check(got_q[Os * (1 + tbl[i].exp_nd)] == bit'(tbl[i].exp_par),
                      $sformatf("vec%0d parity", i), int'(got_q[Os * (1 + tbl[i].exp_nd)]),
                      tbl[i].exp_par);
            end
        end

        // Mid-frame request, config change and break must not touch the frame in flight.
        send(8'h96, 8, 1, 0, 4, 1'b0, 1'b1, 1'b0, "disturb");
        tx_break = 1'b0;
        step(1'b0);
        step(1'b0);
        check(s_tx == 1'b1, "break release", int'(s_tx), 1);

        // Reset five ticks into data bit 3.
        din      = 8'h5A;
        cfg_dbit = 4'd8;
        cfg_par  = 2'd0;
        cfg_stop = 2'd0;
        tx_start = 1'b1;
        step(1'b0);
        tx_start = 1'b0;
        n     = 0;
        cyc   = 0;
        dones = 0;
        while (n < Os * 4 + 5 && cyc < 1000) begin
            step(cyc % 2 == 1);
            if (cyc % 2 == 1) n++;
            if (s_done) dones++;
            cyc++;
        end
        check(n == Os * 4 + 5, "abort reach", n, Os * 4 + 5);
        reset = 1'b1;
        step(1'b1);
        check(s_tx == 1'b1, "abort tx", int'(s_tx), 1);
        if (s_done) dones++;
        reset = 1'b0;
        step(1'b0);
        check(s_ready == 1'b1, "abort ready", int'(s_ready), 1);
        check(s_busy == 1'b0, "abort busy", int'(s_busy), 0);
        check(dones == 0, "abort no done", dones, 0);
        send(8'h3C, 8, 0, 0, 4, 1'b1, 1'b0, 1'b0, "post abort");

        // Random frames against the model, including out-of-range widths.
        for (int i = 0; i < 25; i++) begin
            send(8'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
                 bit'($urandom_range(0, 1)), 1'b0, bit'($urandom_range(0, 1)),
                 $sformatf("rnd%0d", i));
        end
        step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
